// File: rtl/uart_cfg_sequencer.sv
// AXI4-Lite master that writes the 16550 setup sequence (LCR/DLL/DLM/LCR/FCR/IER) on a start pulse.
// Define CFG_READBACK_EN to read back and verify every register except the write-only FCR.
module uart_cfg_sequencer #(
    parameter logic [12:0] BASE_ADDR = 13'h1000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_areset,
    input  logic        start,
    input  logic [1:0]  cfg_wlen,
    input  logic        cfg_stop,
    input  logic        cfg_parity,
    input  logic        cfg_even,
    input  logic [15:0] cfg_divisor,
    input  logic [1:0]  cfg_fifo_trig,
    input  logic [2:0]  cfg_ier,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [12:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [12:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    // Handshakes: a beat transfers on a rising edge where valid and ready are both high; a valid
    // stays high with stable payload until then and drops the cycle after, never re-asserted.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_RESP   = 3'd2,
        S_NEXT   = 3'd3,
        S_FINISH = 3'd4
`ifdef CFG_READBACK_EN
        , S_READ = 3'd5
`endif
    } state_t;

    localparam logic [2:0] LAST_STEP = 3'd5;
    localparam logic [7:0] TMR_LAST  = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic        err_set;
    logic [2:0]  step_q;
    logic [12:0] addr_q;
    logic [7:0]  data_q;
    logic [4:0]  lcr_q;
    logic [15:0] div_q;
    logic [1:0]  trig_q;
    logic [2:0]  ier_q;
    logic        aw_done;
    logic        w_done;
    logic [7:0]  tmr_q;
    logic        tmr_last;
    logic        error_q;

    function automatic logic [12:0] step_addr(input logic [2:0] s);
        case (s)
            3'd0, 3'd3: step_addr = BASE_ADDR + 13'h00C;
            3'd2, 3'd5: step_addr = BASE_ADDR + 13'h004;
            3'd4:       step_addr = BASE_ADDR + 13'h008;
            default:    step_addr = BASE_ADDR;
        endcase
    endfunction

    // lcr is {even, parity, stop, wlen}; bit 7 of LCR is DLAB.
    function automatic logic [7:0] step_data(input logic [2:0] s, input logic [4:0] lcr,
                                             input logic [15:0] div, input logic [1:0] trig,
                                             input logic [2:0] ier);
        case (s)
            3'd0:    step_data = {1'b1, 2'b00, lcr};
            3'd1:    step_data = div[7:0];
            3'd2:    step_data = div[15:8];
            3'd3:    step_data = {1'b0, 2'b00, lcr};
            3'd4:    step_data = {trig, 2'b00, 4'b1111};
            3'd5:    step_data = {5'b00000, ier};
            default: step_data = 8'h00;
        endcase
    endfunction

    assign tmr_last = (tmr_q == TMR_LAST);

`ifdef CFG_READBACK_EN
    logic ar_done;
    logic rd_ok;
    logic unused_ok;
    assign rd_ok     = (m_axi_rresp == 2'b00) && (m_axi_rdata[7:0] == data_q);
    assign unused_ok = ^m_axi_rdata[31:8];
`else
    logic unused_ok;
    assign unused_ok = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
`endif

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) begin
                    state_next = S_RESP;
                end else if (tmr_last) begin
                    err_set    = 1'b1;
                    state_next = S_FINISH;
                end
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        err_set    = 1'b1;
                        state_next = S_FINISH;
                    end
`ifdef CFG_READBACK_EN
                    else if (step_q != 3'd4) state_next = S_READ;
`endif
                    else state_next = S_NEXT;
                end else if (tmr_last) begin
                    err_set    = 1'b1;
                    state_next = S_FINISH;
                end
            end
`ifdef CFG_READBACK_EN
            S_READ: begin
                if (ar_done && m_axi_rvalid) begin
                    err_set    = !rd_ok;
                    state_next = rd_ok ? S_NEXT : S_FINISH;
                end else if (tmr_last) begin
                    err_set    = 1'b1;
                    state_next = S_FINISH;
                end
            end
`endif
            S_NEXT:   state_next = (step_q == LAST_STEP) ? S_FINISH : S_ISSUE;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != S_IDLE) && (state != S_FINISH);
        done          = (state == S_FINISH);
        error         = error_q;
        m_axi_awaddr  = addr_q;
        m_axi_awvalid = (state == S_ISSUE) && !aw_done;
        m_axi_wdata   = {24'h000000, data_q};
        m_axi_wstrb   = 4'b0001;
        m_axi_wvalid  = (state == S_ISSUE) && !w_done;
        m_axi_bready  = (state == S_RESP);
`ifdef CFG_READBACK_EN
        m_axi_araddr  = addr_q;
        m_axi_arvalid = (state == S_READ) && !ar_done;
        m_axi_rready  = (state == S_READ) && ar_done;
`else
        m_axi_araddr  = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
`endif
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            step_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            lcr_q   <= '0;
            div_q   <= '0;
            trig_q  <= '0;
            ier_q   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            tmr_q   <= '0;
            error_q <= 1'b0;
`ifdef CFG_READBACK_EN
            ar_done <= 1'b0;
`endif
        end else begin
            // Acceptance flags live only inside their phase; they clear on the way out.
            aw_done <= (state == S_ISSUE) && (aw_done || (m_axi_awvalid && m_axi_awready));
            w_done  <= (state == S_ISSUE) && (w_done || (m_axi_wvalid && m_axi_wready));
`ifdef CFG_READBACK_EN
            ar_done <= (state == S_READ) && (ar_done || (m_axi_arvalid && m_axi_arready));
`endif
            tmr_q <= (state_next != state) ? 8'd0 : tmr_q + 8'd1;
            if (err_set) error_q <= 1'b1;
            if (state == S_IDLE && start) begin
                lcr_q   <= {cfg_even, cfg_parity, cfg_stop, cfg_wlen};
                div_q   <= cfg_divisor;
                trig_q  <= cfg_fifo_trig;
                ier_q   <= cfg_ier;
                error_q <= 1'b0;
                step_q  <= 3'd0;
                addr_q  <= step_addr(3'd0);
                data_q  <= step_data(3'd0, {cfg_even, cfg_parity, cfg_stop, cfg_wlen},
                                     cfg_divisor, cfg_fifo_trig, cfg_ier);
            end else if (state == S_NEXT && step_q != LAST_STEP) begin
                step_q <= step_q + 3'd1;
                addr_q <= step_addr(step_q + 3'd1);
                data_q <= step_data(step_q + 3'd1, lcr_q, div_q, trig_q, ier_q);
            end
        end
    end

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Directed bench for uart_cfg_sequencer: AXI-Lite slave model with scoreboard and vector table.
module tb_uart_cfg_sequencer;
  localparam int W = 49;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [1:0]  cfg_wlen = '0;
  logic        cfg_stop = 1'b0, cfg_parity = 1'b0, cfg_even = 1'b0;
  logic [15:0] cfg_divisor = '0;
  logic [1:0]  cfg_fifo_trig = '0;
  logic [2:0]  cfg_ier = '0;
  logic        busy, done, error;
  logic [12:0] m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic [31:0] m_axi_rdata;

  uart_cfg_sequencer dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .start(start),
    .cfg_wlen(cfg_wlen), .cfg_stop(cfg_stop), .cfg_parity(cfg_parity), .cfg_even(cfg_even),
    .cfg_divisor(cfg_divisor), .cfg_fifo_trig(cfg_fifo_trig), .cfg_ier(cfg_ier),
    .busy(busy), .done(done), .error(error),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  typedef struct {
    logic [1:0]  wlen;
    logic        stop, parity, even;
    logic [15:0] div;
    logic [1:0]  trig;
    logic [2:0]  ier;
    int          aw_dly, w_dly;
    bit          poke;
    logic [47:0] exp_bytes;
  } vec_t;

  vec_t        vecs[4];
  logic [12:0] exp_addr[6];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  int n_vec = 0, n_miss = 0;

  // slave model knobs and state
  int aw_dly, w_dly, aw_wait, w_wait, err_idx, b_hold, rd_bad;
  bit aw_stuck, aw_got, w_got, ar_pend;
  int aw_hs, w_hs, wr_idx, rd_cnt, proto_err, done_cnt;
  logic [12:0] cur_addr;
  logic [31:0] cur_data;
  logic [3:0]  cur_strb;
  logic [7:0]  last_byte;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic slave_clear();
    @(negedge clk); #1;
    aw_dly = 0; w_dly = 0; aw_wait = 0; w_wait = 0; err_idx = -1; b_hold = -1; rd_bad = -1;
    aw_stuck = 0; aw_got = 0; w_got = 0; ar_pend = 0;
    aw_hs = 0; w_hs = 0; wr_idx = 0; rd_cnt = 0; proto_err = 0; done_cnt = 0;
    last_byte = '0;
    act_q.delete(); exp_q.delete();
  endtask

  initial begin : slave
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
        continue;
      end
      if (done) done_cnt++;
      if (m_axi_awready) begin
        m_axi_awready = 0; aw_got = 1;
      end else if (m_axi_awvalid) begin
        if (aw_got) proto_err++;
        else if (!aw_stuck && aw_wait >= aw_dly) begin
          m_axi_awready = 1; cur_addr = m_axi_awaddr; aw_hs++;
        end else aw_wait++;
      end
      if (m_axi_wready) begin
        m_axi_wready = 0; w_got = 1;
      end else if (m_axi_wvalid) begin
        if (w_got) proto_err++;
        else if (w_wait >= w_dly) begin
          m_axi_wready = 1; cur_data = m_axi_wdata; cur_strb = m_axi_wstrb; w_hs++;
        end else w_wait++;
      end
      if (m_axi_bvalid) begin
        m_axi_bvalid = 0;
        act_q.push_back({cur_addr, cur_data, cur_strb});
        last_byte = cur_data[7:0];
        aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; wr_idx++;
      end else if (m_axi_bready) begin
        if (!(aw_got && w_got)) proto_err++;
        else if (wr_idx != b_hold) begin
          m_axi_bvalid = 1;
          m_axi_bresp = (wr_idx == err_idx) ? 2'b10 : 2'b00;
        end
      end
      if (m_axi_rvalid) m_axi_rvalid = 0;
      else if (ar_pend && m_axi_rready) begin
        m_axi_rvalid = 1; m_axi_rresp = 2'b00;
        m_axi_rdata = {24'h0, (rd_cnt == rd_bad) ? ~last_byte : last_byte};
        rd_cnt++; ar_pend = 0;
      end
      if (m_axi_arready) begin
        m_axi_arready = 0; ar_pend = 1;
      end else if (m_axi_arvalid && !ar_pend && !m_axi_rvalid) begin
        if (m_axi_araddr != cur_addr) proto_err++;
        m_axi_arready = 1;
      end
`ifndef CFG_READBACK_EN
      if (m_axi_arvalid || m_axi_rready || m_axi_araddr != '0) proto_err++;
`endif
    end
  end

  task automatic push_exp(input logic [47:0] bytes, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({exp_addr[i], 24'h0, bytes[47-8*i -: 8], 4'b0001});
  endtask

  task automatic do_start(input vec_t v, input string tag);
    @(negedge clk);
    cfg_wlen = v.wlen; cfg_stop = v.stop; cfg_parity = v.parity; cfg_even = v.even;
    cfg_divisor = v.div; cfg_fifo_trig = v.trig; cfg_ier = v.ier;
    start = 1;
    @(negedge clk);
    start = 0;
    check({tag, "_busy_error"}, 64'({busy, error}), 64'(2'b10));
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'(1'b1));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'({done, busy, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'(0));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 64'(act_q.size()), 64'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_write"}, 64'(act_q.pop_front()), 64'(exp_q.pop_front()));
    check({tag, "_proto"}, 64'(proto_err), 64'(0));
  endtask

  initial begin : main
    int cyc;
    exp_addr = '{13'h100C, 13'h1000, 13'h1004, 13'h100C, 13'h1008, 13'h1004};
    vecs[0] = '{2'b11, 1'b0, 1'b0, 1'b0, 16'h0036, 2'b10, 3'b111, 0, 0, 1'b0, 48'h83_36_00_03_8F_07};
    vecs[1] = '{2'b00, 1'b1, 1'b1, 1'b1, 16'h1234, 2'b00, 3'b000, 0, 3, 1'b1, 48'h9C_34_12_1C_0F_00};
    vecs[2] = '{2'b10, 1'b0, 1'b1, 1'b0, 16'hFFFF, 2'b11, 3'b101, 3, 0, 1'b0, 48'h8A_FF_FF_0A_CF_05};
    vecs[3] = '{2'b01, 1'b1, 1'b0, 1'b1, 16'h0100, 2'b01, 3'b010, 1, 2, 1'b0, 48'h95_00_01_15_4F_02};

    // reset held for three cycles
    #2 rst = 1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                             m_axi_arvalid, m_axi_rready}), 64'(0));
    check("reset_wstrb", 64'(m_axi_wstrb), 64'(4'b0001));
    check("reset_addr_data", 64'({m_axi_awaddr, m_axi_araddr, m_axi_wdata}), 64'(0));
    rst = 0;
    slave_clear();

    for (int k = 0; k < 4; k++) begin
      slave_clear();
      aw_dly = vecs[k].aw_dly; w_dly = vecs[k].w_dly;
      push_exp(vecs[k].exp_bytes, 6);
      do_start(vecs[k], $sformatf("vec%0d", k));
      if (vecs[k].poke) begin
        cfg_divisor = 16'hDEAD; cfg_wlen = 2'b00; cfg_ier = 3'b111; start = 1;
        @(negedge clk);
        start = 0;
      end
      wait_done($sformatf("vec%0d", k), cyc);
      check($sformatf("vec%0d_error", k), 64'(error), 64'(0));
      check($sformatf("vec%0d_aw_hs", k), 64'(aw_hs), 64'(6));
      check_writes($sformatf("vec%0d", k));
    end

    // SLVERR on the DLL write aborts before DLM
    slave_clear();
    err_idx = 1;
    push_exp(vecs[0].exp_bytes, 2);
    do_start(vecs[0], "bresp");
    wait_done("bresp", cyc);
    check("bresp_error", 64'(error), 64'(1));
    check("bresp_aw_hs", 64'(aw_hs), 64'(2));
    check_writes("bresp");
    slave_clear();
    push_exp(vecs[1].exp_bytes, 6);
    do_start(vecs[1], "err_clear");
    wait_done("err_clear", cyc);
    check("err_clear_error", 64'(error), 64'(0));
    check_writes("err_clear");

    // awready never rises: timeout from ISSUE entry
    slave_clear();
    aw_stuck = 1;
    do_start(vecs[0], "timeout");
    wait_done("timeout", cyc);
    check("timeout_cycles", 64'(cyc), 64'(255));
    check("timeout_error_aw", 64'({error, m_axi_awvalid}), 64'(2'b10));

    // async reset while waiting for the DLM response
    slave_clear();
    b_hold = 2;
    do_start(vecs[0], "midrst");
    cyc = 0;
    while (!(m_axi_bready && wr_idx == 2) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reached", 64'({m_axi_bready, 3'(wr_idx)}), 64'({1'b1, 3'd2}));
    rst = 1;
    #1;
    check("midrst_ctrl", 64'({busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                              m_axi_arvalid, m_axi_rready}), 64'(0));
    check("midrst_addr_data", 64'({m_axi_awaddr, m_axi_wdata}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 0;
    slave_clear();
    push_exp(vecs[0].exp_bytes, 6);
    do_start(vecs[0], "restart");
    wait_done("restart", cyc);
    check("restart_error", 64'(error), 64'(0));
    check_writes("restart");

`ifdef CFG_READBACK_EN
    // corrupted DLL readback
    slave_clear();
    rd_bad = 1;
    push_exp(vecs[0].exp_bytes, 2);
    do_start(vecs[0], "rdbad");
    wait_done("rdbad", cyc);
    check("rdbad_error", 64'(error), 64'(1));
    check("rdbad_reads", 64'(rd_cnt), 64'(2));
    check_writes("rdbad");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
